// File: rtl/wisc_pkg.sv
// Shared constants and FSM encoding for the fetch stage.
package wisc_pkg;
  localparam int          W_DEF   = 16;
  localparam logic [15:0] NOP_DEF = 16'h0800;

  typedef enum logic [1:0] {RUN, WAIT_MEM, DRAIN, HALTED} fetch_state_t;
endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/response bus between fetch and imem.
interface pc_fetch_ctrl_if
  import wisc_pkg::*;
#(parameter int W = W_DEF) ();
  logic [W-1:0] imem_addr;
  logic         imem_rd;
  logic [W-1:0] imem_data;
  logic         imem_ready;

  modport master (output imem_addr, imem_rd, input imem_data, imem_ready);
  modport slave  (input imem_addr, imem_rd, output imem_data, imem_ready);
endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register; flush wins over load, neither means hold.
module ifid_reg #(
  parameter int           W   = 16,
  parameter logic [W-1:0] NOP = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         flush,
  input  logic [W-1:0] instr_in,
  input  logic [W-1:0] pc2_in,
  output logic [W-1:0] instr,
  output logic [W-1:0] pc2,
  output logic         valid
);
  always_ff @(posedge clk) begin
    if (rst) begin
      instr <= NOP;
      pc2   <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP;
      valid <= 1'b0;
    end else if (load) begin
      instr <= instr_in;
      pc2   <= pc2_in;
      valid <= 1'b1;
    end
  end
endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch controller: PC sequencing, redirect/drain handling and IF/ID control.
module pc_fetch_ctrl
  import wisc_pkg::*;
#(
  parameter int           W   = W_DEF,
  parameter logic [W-1:0] NOP = W'(NOP_DEF)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   branch_taken,
  input  logic [W-1:0]           branch_target,
  input  logic                   jump,
  input  logic [W-1:0]           jump_target,
  input  logic                   stall,
  input  logic                   halt,
  pc_fetch_ctrl_if.master        imem,
  output logic [W-1:0]           ifid_instr,
  output logic [W-1:0]           ifid_pc2,
  output logic                   ifid_valid,
  output logic                   flush,
  output logic                   halted
);
  fetch_state_t state;
  logic [W-1:0] pc, drain_addr, pc_plus2, tgt;
  logic         redirect, active, ld, fl;

  assign redirect = branch_taken | jump;
  assign tgt      = branch_taken ? {branch_target[W-1:1], 1'b0} : {jump_target[W-1:1], 1'b0};
  assign pc_plus2 = pc + W'(2);
  assign active   = (state == RUN) || (state == WAIT_MEM);

  // DRAIN keeps presenting the abandoned address until its data returns.
  assign imem.imem_addr = (state == DRAIN) ? drain_addr : pc;
  assign imem.imem_rd   = !rst && (state != HALTED);

  assign ld = active && !redirect && !halt && !stall && imem.imem_ready;
  assign fl = (state != HALTED) &&
              (redirect || halt || (active && !stall && !imem.imem_ready));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      pc         <= '0;
      drain_addr <= '0;
      flush      <= 1'b0;
      halted     <= 1'b0;
    end else begin
      flush <= 1'b0;
      case (state)
        RUN, WAIT_MEM: begin
          if (redirect) begin
            pc    <= tgt;
            flush <= 1'b1;
            if (!imem.imem_ready) begin
              state      <= DRAIN;
              drain_addr <= pc;
            end else begin
              state <= RUN;
            end
          end else if (halt) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (stall) begin
            state <= state;
          end else if (imem.imem_ready) begin
            pc    <= pc_plus2;
            state <= RUN;
          end else begin
            state <= WAIT_MEM;
          end
        end
        DRAIN: begin
          if (redirect) begin
            pc    <= tgt;
            flush <= 1'b1;
          end else if (halt) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (imem.imem_ready) begin
            state <= RUN;
          end
        end
        HALTED:  halted <= 1'b1;
        default: state  <= RUN;
      endcase
    end
  end

  ifid_reg #(.W(W), .NOP(NOP)) u_ifid (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .flush    (fl),
    .instr_in (imem.imem_data),
    .pc2_in   (pc_plus2),
    .instr    (ifid_instr),
    .pc2      (ifid_pc2),
    .valid    (ifid_valid)
  );
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: directed scenarios then random traffic.
module tb_pc_fetch_ctrl;
  import wisc_pkg::*;
  localparam int           W    = 16;
  localparam logic [W-1:0] NOPW = NOP_DEF;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         branch_taken = 1'b0, jump = 1'b0, stall = 1'b0, halt = 1'b0;
  logic [W-1:0] branch_target = '0, jump_target = '0;
  logic [W-1:0] ifid_instr, ifid_pc2;
  logic         ifid_valid, flush, halted;

  pc_fetch_ctrl_if #(.W(W)) bus ();

  pc_fetch_ctrl #(.W(W), .NOP(NOPW)) dut (
    .clk           (clk),
    .rst           (rst),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .stall         (stall),
    .halt          (halt),
    .imem          (bus.master),
    .ifid_instr    (ifid_instr),
    .ifid_pc2      (ifid_pc2),
    .ifid_valid    (ifid_valid),
    .flush         (flush),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         full;
    logic [W-1:0] addr;
    logic         rd;
    logic [W-1:0] instr;
    logic [W-1:0] pc2;
    logic         valid;
    logic         flush;
    logic         halted;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_bad = 0, cyc_no = 0;

  // Reference model: architectural view of the fetch unit.
  logic [W-1:0] m_pc = '0, m_old = '0, m_instr = '0, m_pc2 = '0;
  logic         m_drain = 0, m_halt = 0, m_valid = 0, m_flush = 0, m_known = 0;

  task automatic model_edge();
    logic [W-1:0] t;
    if (rst) begin
      m_known = 1; m_pc = '0; m_old = '0; m_drain = 0; m_halt = 0;
      m_instr = NOPW; m_pc2 = '0; m_valid = 0; m_flush = 0;
    end else begin
      m_flush = 0;
      if (!m_halt) begin
        if (branch_taken || jump) begin
          t = branch_taken ? branch_target : jump_target;
          t[0] = 1'b0;
          if (!m_drain) begin
            m_drain = !bus.imem_ready;
            m_old   = m_pc;
          end
          m_pc = t; m_flush = 1; m_instr = NOPW; m_valid = 0;
        end else if (halt) begin
          m_halt = 1; m_drain = 0; m_instr = NOPW; m_valid = 0;
        end else if (m_drain) begin
          if (bus.imem_ready) m_drain = 0;
        end else if (stall) begin
          m_pc = m_pc;
        end else if (bus.imem_ready) begin
          m_instr = bus.imem_data; m_pc2 = m_pc + 16'd2; m_valid = 1; m_pc = m_pc + 16'd2;
        end else begin
          m_instr = NOPW; m_valid = 0;
        end
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.full   = m_known;
    e.addr   = m_drain ? m_old : m_pc;
    e.rd     = !rst && !m_halt;
    e.instr  = m_instr;
    e.pc2    = m_pc2;
    e.valid  = m_valid;
    e.flush  = m_flush;
    e.halted = m_halt;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic ok;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cyc_no++;
      n_cmp++;
      if (e.full)
        ok = (bus.imem_addr === e.addr) && (bus.imem_rd === e.rd) && (ifid_instr === e.instr) &&
             (ifid_pc2 === e.pc2) && (ifid_valid === e.valid) && (flush === e.flush) &&
             (halted === e.halted);
      else
        ok = (bus.imem_rd === e.rd);
      if (!ok) begin
        n_bad++;
        $display("FAIL outputs cyc%0d: got addr=%h rd=%b instr=%h pc2=%h v=%b fl=%b h=%b want addr=%h rd=%b instr=%h pc2=%h v=%b fl=%b h=%b",
                 cyc_no, bus.imem_addr, bus.imem_rd, ifid_instr, ifid_pc2, ifid_valid, flush, halted,
                 e.addr, e.rd, e.instr, e.pc2, e.valid, e.flush, e.halted);
      end
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // One clock: apply inputs, predict visible outputs, let the edge happen.
  task automatic cyc(input logic r, input logic bt, input logic [W-1:0] btg, input logic j,
                     input logic [W-1:0] jtg, input logic st, input logic h, input logic rdy,
                     input logic [W-1:0] d);
    rst = r; branch_taken = bt; branch_target = btg; jump = j; jump_target = jtg;
    stall = st; halt = h; bus.imem_ready = rdy; bus.imem_data = d;
    push_exp();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic fetch(input logic rdy);
    cyc(0, 0, '0, 0, '0, 0, 0, rdy, W'($urandom));
  endtask

  initial begin
    logic r, bt, j, st, h, rdy;
    bus.imem_ready = 1'b0;
    bus.imem_data  = '0;
    @(posedge clk);
    #1;
    cyc(1, 0, '0, 0, '0, 0, 0, 1, 16'h1111);
    cyc(1, 0, '0, 0, '0, 0, 0, 1, 16'h2222);
    chk("rst_instr", ifid_instr, NOPW);
    chk("rst_valid", W'(ifid_valid), '0);
    chk("rst_halted", W'(halted), '0);

    for (int i = 0; i < 4; i++) begin
      chk("seq_addr", bus.imem_addr, W'(2 * i));
      fetch(1);
      chk("seq_pc2", ifid_pc2, W'(2 * i + 2));
      chk("seq_valid", W'(ifid_valid), 16'd1);
    end
    for (int i = 0; i < 4; i++) fetch(1);
    chk("br_pc", bus.imem_addr, 16'h0010);
    cyc(0, 1, 16'h0040, 0, '0, 0, 0, 1, 16'hAAAA);
    chk("br_flush", W'(flush), 16'd1);
    chk("br_valid", W'(ifid_valid), '0);
    chk("br_addr", bus.imem_addr, 16'h0040);
    fetch(1);
    chk("br_flush_pulse", W'(flush), '0);

    cyc(0, 0, '0, 1, 16'h0100, 0, 0, 0, 16'hBBBB);
    chk("drain_addr", bus.imem_addr, 16'h0042);
    chk("drain_rd", W'(bus.imem_rd), 16'd1);
    cyc(0, 0, '0, 0, '0, 0, 0, 1, 16'hBEEF);
    chk("drain_discard", W'(ifid_valid), '0);
    chk("drain_next", bus.imem_addr, 16'h0100);
    cyc(0, 0, '0, 0, '0, 0, 0, 1, 16'h1234);
    chk("drain_fetch", ifid_instr, 16'h1234);

    cyc(0, 0, '0, 1, 16'h0200, 0, 0, 0, 16'h0);
    cyc(0, 1, 16'h0300, 0, '0, 0, 0, 0, 16'h0);
    chk("drain2_flush", W'(flush), 16'd1);
    chk("drain2_addr", bus.imem_addr, 16'h0102);
    cyc(0, 0, '0, 0, '0, 0, 0, 1, 16'hCAFE);
    chk("drain2_next", bus.imem_addr, 16'h0300);

    cyc(0, 1, 16'h0050, 0, '0, 1, 0, 1, 16'h5555);
    chk("stall_redir", bus.imem_addr, 16'h0050);
    fetch(1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, '0, 0, '0, 1, 0, 1, W'($urandom));
      chk("stall_pc", bus.imem_addr, 16'h0052);
    end

    cyc(0, 0, '0, 1, 16'hFFFF, 0, 0, 1, 16'h0);
    chk("wrap_pre", bus.imem_addr, 16'hFFFE);
    fetch(1);
    chk("wrap_addr", bus.imem_addr, 16'h0000);
    chk("wrap_pc2", ifid_pc2, 16'h0000);

    cyc(0, 0, '0, 0, '0, 0, 1, 1, 16'h0);
    chk("halt_h", W'(halted), 16'd1);
    chk("halt_rd", W'(bus.imem_rd), '0);
    cyc(0, 1, 16'h0400, 1, 16'h0500, 0, 0, 1, 16'h0);
    fetch(1);
    chk("halt_hold", W'(halted), 16'd1);

    cyc(1, 0, '0, 0, '0, 0, 0, 1, 16'h0);
    cyc(0, 0, '0, 1, 16'h0600, 0, 0, 0, 16'h0);
    cyc(1, 0, '0, 0, '0, 0, 0, 1, 16'hDEAD);
    fetch(1);
    chk("rst_drain_addr", bus.imem_addr, 16'h0002);
    chk("rst_drain_pc2", ifid_pc2, 16'h0002);

    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 99) < (m_halt ? 25 : 2));
      bt  = ($urandom_range(0, 99) < 8);
      j   = ($urandom_range(0, 99) < 6);
      st  = ($urandom_range(0, 99) < 20);
      h   = ($urandom_range(0, 99) < 2);
      rdy = ($urandom_range(0, 99) < 70);
      cyc(r, bt, W'($urandom), j, W'($urandom), st, h, rdy, W'($urandom));
    end

    @(negedge clk);
    #1;
    chk("queue_empty", W'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL use clk, a single clock; all state updates on rising edge.
REQ-002 SHALL use rst as the reset: synchronous, active-high.
REQ-003 SHALL provide parameter W, default 16, datapath and PC width in bits.
REQ-004 SHALL provide parameter NOP, default 16'h0800, the instruction word loaded into IF/ID on flush/reset/halt.
REQ-005 SHALL provide input branch_taken, 1 bit, the resolved conditional-branch decision from branch_control.
REQ-006 SHALL provide input branch_target, W bits, the target address for a taken branch.
REQ-007 SHALL provide input jump, 1 bit, the unconditional jump/jump-register request.
REQ-008 SHALL provide input jump_target, W bits, the jump destination address.
REQ-009 SHALL provide input stall, 1 bit, a hazard hold from decode.
REQ-010 SHALL provide input halt, 1 bit, indicating a HALT has been decoded.
REQ-011 SHALL provide output imem_addr, W bits, the instruction memory address.
REQ-012 SHALL provide output imem_rd, 1 bit, the instruction memory read request.
REQ-013 SHALL provide input imem_data, W bits, the instruction memory read data.
REQ-014 SHALL provide input imem_ready, 1 bit, signalling that imem_data is valid this cycle.
REQ-015 SHALL provide output ifid_instr, W bits, the IF/ID instruction register.
REQ-016 SHALL provide output ifid_pc2, W bits, the IF/ID PC+2 register.
REQ-017 SHALL provide output ifid_valid, 1 bit, the IF/ID valid flag.
REQ-018 SHALL provide output flush, 1 bit, a one-cycle pulse on accepted redirect.
REQ-019 SHALL provide output halted, 1 bit, asserted while the fetch unit is halted.

Function
REQ-020 SHALL implement states RUN, WAIT_MEM, DRAIN, HALTED.
REQ-021 SHALL drive imem_addr=pc and imem_rd=1 in RUN and WAIT_MEM.
REQ-022 SHALL accept a fetch when in RUN/WAIT_MEM with imem_ready=1, stall=0 and no redirect: ifid_instr<=imem_data, ifid_pc2<=pc+2, ifid_valid<=1, pc<=pc+2, next state RUN.
REQ-023 SHALL compute pc+2 modulo 2^W, so 16'hFFFE wraps to 16'h0000.
REQ-024 SHALL, when imem_ready=0 with no redirect, move to WAIT_MEM, hold pc, and load ifid_valid<=0 and ifid_instr<=NOP unless stall=1.
REQ-025 SHALL, when stall=1 with no redirect, hold pc, ifid_instr, ifid_pc2 and ifid_valid unchanged; ready data is not consumed and the same address is re-requested next cycle.
REQ-026 SHALL treat redirect as branch_taken|jump, giving branch_taken priority over jump when both are asserted.
REQ-027 SHALL give redirect priority over stall and halt.
REQ-028 SHALL, on redirect: pc<=selected target, ifid_instr<=NOP, ifid_valid<=0, flush=1 for exactly that cycle, with fetched data discarded.
REQ-029 SHALL, on redirect while imem_ready=0 (access in flight), go to DRAIN.
REQ-030 SHALL, in DRAIN, hold imem_addr at the old address with imem_rd=1, discard data when imem_ready=1, then go to RUN fetching the new pc.
REQ-031 SHALL, on a second redirect during DRAIN, overwrite pc with the new target, remain in DRAIN, and pulse flush again.
REQ-032 SHALL, on halt=1 with no redirect, go to HALTED: imem_rd=0, pc frozen, ifid_instr=NOP, ifid_valid=0, halted=1.
REQ-033 SHALL leave HALTED only through rst and ignore redirect while in HALTED.
REQ-034 SHALL force imem_addr=pc and all targets even-aligned, with bit 0 forced to 0.

Reset
REQ-035 SHALL, on rst=1 at a clock edge: pc=0, state RUN, ifid_instr=NOP, ifid_pc2=0, ifid_valid=0, flush=0, halted=0.
REQ-036 SHALL hold imem_rd=0 during any rst=1 cycle.
REQ-037 SHALL let rst mid-DRAIN or mid-HALTED abandon all state, with no data from a prior access captured afterwards.
REQ-038 SHALL start the first fetch at address 0 in the cycle after rst deasserts.

Structure
REQ-039 SHALL place the state encoding, the NOP constant and the W default in shared package wisc_pkg.
REQ-040 SHALL instantiate one sub-module ifid_reg, the IF/ID register with load, hold and flush controls; the FSM and PC logic stay in pc_fetch_ctrl.

Verification
REQ-041 SHALL cover sequential fetch: rst then imem_ready=1 for 4 cycles -> imem_addr 0,2,4,6; ifid_pc2 2,4,6,8; ifid_valid=1 from cycle 2.
REQ-042 SHALL cover a taken branch: branch_taken=1, branch_target=16'h0040 at pc=16'h0010 -> flush=1 one cycle, ifid_valid=0, next imem_addr=16'h0040.
REQ-043 SHALL cover redirect in flight: imem_ready=0 and jump=1, jump_target=16'h0100 -> DRAIN, returned word discarded, following fetch at 16'h0100.
REQ-044 SHALL cover stall against redirect: stall=1 with branch_taken=1 in the same cycle -> redirect taken; stall alone for 3 cycles -> IF/ID and pc unchanged.
REQ-045 SHALL cover wrap and halt: pc=16'hFFFE fetch -> next pc 16'h0000; halt=1 -> imem_rd=0, halted=1, held until rst.
